// File: rtl/engine_filter_cond_control_pkg.sv
// Shared types for the filter-condition engine control slice.
//   FilterCondConfigurationParameters : filter op, mask, break-on-fail enable
//   EnginePacketData                  : two 16-bit operand fields
//   FilterCondControlState            : sequencer states
//   FilterCondInflight                : {valid, last} record riding alongside the kernel
package engine_filter_cond_control_pkg;

  localparam int FILTER_COND_KERNEL_LATENCY = 2;

  typedef enum logic [1:0] {
    FILTER_NOP = 2'd0,
    FILTER_GT  = 2'd1,
    FILTER_LT  = 2'd2,
    FILTER_EQ  = 2'd3
  } FilterCondOp;

  typedef struct packed {
    FilterCondOp filter_op;
    logic [3:0]  filter_mask;
    logic        break_pass;
  } FilterCondConfigurationParameters;

  typedef struct packed {
    logic [15:0] field_a;
    logic [15:0] field_b;
  } EnginePacketData;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CONFIG = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } FilterCondControlState;

  typedef struct packed {
    logic valid;
    logic last;
  } FilterCondInflight;

endpackage

// File: rtl/engine_filter_cond_fifo.sv
// Synchronous FIFO of EnginePacketData plus a last bit.
//   clk_i/rst_ni   : clock, synchronous active-low reset
//   push_i/..._i   : write entry (caller guarantees not full)
//   mark_last_i    : set the last bit of the newest entry still held
//   pop_i          : consume head (caller gates with valid_o)
//   valid_o/data_o/last_o : head; data/last read as 0 when empty
//   count_o        : occupancy
module engine_filter_cond_fifo
  import engine_filter_cond_control_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  EnginePacketData push_data_i,
  input  logic            push_last_i,
  input  logic            mark_last_i,
  input  logic            pop_i,
  output logic            valid_o,
  output EnginePacketData data_o,
  output logic            last_o,
  output logic [AW:0]     count_o
);

  EnginePacketData  mem_q [DEPTH];
  logic [DEPTH-1:0] last_q;
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;

  assign valid_o = (cnt_q != '0);
  assign data_o  = valid_o ? mem_q[rd_q] : '0;
  assign last_o  = valid_o & last_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= push_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      if (push_i) begin
        last_q[wr_q] <= push_last_i;
        wr_q         <= wr_q + AW'(1);
      end
      // The newest entry leaves this cycle if it is the only one and is popped.
      if (mark_last_i && (cnt_q != '0) && !(pop_i && (cnt_q == (AW+1)'(1))))
        last_q[wr_q - AW'(1)] <= 1'b1;
      if (pop_i) rd_q <= rd_q + AW'(1);
      unique case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/engine_filter_cond_control.sv
// Sequencer / flow controller around the 2-cycle filter kernel.
// Latches config on start, clears the kernel, issues packets under credit,
// tracks in-flight packets, keeps flag=1 results in an output FIFO, and
// handles end-of-stream, break-on-fail and done signalling.
// Ports: ap_clk/ap_rst_n (sync active-low); start_in/config_in; in_* input
// stream; out_* output stream; kernel_* kernel interface; busy/done/break
// status; passed/dropped counters.
// Build option: FILTER_COND_CONTROL_STATS_EN builds live counters; otherwise
// the counter outputs are tied to 0.
module engine_filter_cond_control
  import engine_filter_cond_control_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int KERNEL_LATENCY = FILTER_COND_KERNEL_LATENCY,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst_n,
  input  logic                             start_in,
  input  FilterCondConfigurationParameters config_in,
  input  logic                             in_valid,
  input  EnginePacketData                  in_data,
  input  logic                             in_last,
  output logic                             in_ready,
  output logic                             out_valid,
  output EnginePacketData                  out_data,
  output logic                             out_last,
  input  logic                             out_ready,
  output logic                             kernel_clear_out,
  output logic                             kernel_config_valid_out,
  output FilterCondConfigurationParameters kernel_config_out,
  output logic                             kernel_data_valid_out,
  output EnginePacketData                  kernel_data_out,
  input  logic                             kernel_result_flag_in,
  input  EnginePacketData                  kernel_result_data_in,
  output logic                             busy_out,
  output logic                             done_out,
  output logic                             break_out,
  output logic [COUNT_WIDTH-1:0]           passed_count_out,
  output logic [COUNT_WIDTH-1:0]           dropped_count_out
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(FIFO_DEPTH + KERNEL_LATENCY + 1) + 1;

  FilterCondControlState                state_q;
  FilterCondConfigurationParameters     cfg_q;
  FilterCondInflight [KERNEL_LATENCY-1:0] pipe_q;
  FilterCondInflight                    ret;
  logic          brk_q, clr_q, done_q, busy_q, cfgv_q;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_valid, xfer, keep, brk_hit, mark_last, pop, pipe_empty;
  logic [SW-1:0] occ;

  // Credit: every in-flight packet may still need a FIFO slot.
  always_comb begin
    occ        = SW'(fifo_cnt);
    pipe_empty = 1'b1;
    for (int i = 0; i < KERNEL_LATENCY; i++) begin
      occ = occ + SW'(pipe_q[i].valid);
      if (pipe_q[i].valid) pipe_empty = 1'b0;
    end
  end

  assign ret      = pipe_q[KERNEL_LATENCY-1];
  assign in_ready = (state_q == RUN) && (occ < SW'(FIFO_DEPTH));
  assign xfer     = in_valid && in_ready;

  assign kernel_data_valid_out   = xfer;
  assign kernel_data_out         = xfer ? in_data : '0;
  assign kernel_clear_out        = clr_q;
  assign kernel_config_valid_out = cfgv_q;
  assign kernel_config_out       = cfg_q;
  assign busy_out                = busy_q;
  assign done_out                = done_q;
  assign break_out               = brk_q;

  // After a break every remaining retire is dropped regardless of its flag.
  assign keep      = ret.valid && kernel_result_flag_in && !brk_q;
  assign brk_hit   = ret.valid && !kernel_result_flag_in && cfg_q.break_pass && !brk_q;
  // Stream ends without pushing a last entry: tag the newest buffered one.
  assign mark_last = ret.valid && !keep && (ret.last || brk_hit);
  assign pop       = fifo_valid && out_ready;
  assign out_valid = fifo_valid;

  engine_filter_cond_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (ap_clk),
    .rst_ni      (ap_rst_n),
    .push_i      (keep),
    .push_data_i (kernel_result_data_in),
    .push_last_i (ret.last),
    .mark_last_i (mark_last),
    .pop_i       (pop),
    .valid_o     (fifo_valid),
    .data_o      (out_data),
    .last_o      (out_last),
    .count_o     (fifo_cnt)
  );

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= '{valid: xfer, last: xfer && in_last};
      for (int i = 1; i < KERNEL_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      brk_q   <= 1'b0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      cfgv_q  <= 1'b0;
    end else begin
      clr_q  <= 1'b0;
      done_q <= 1'b0;
      if (brk_hit) brk_q <= 1'b1;
      unique case (state_q)
        IDLE: if (start_in) begin
          cfg_q   <= config_in;
          brk_q   <= 1'b0;
          clr_q   <= 1'b1;
          busy_q  <= 1'b1;
          cfgv_q  <= 1'b1;
          state_q <= CONFIG;
        end
        CONFIG: state_q <= RUN;
        RUN: if (brk_hit || (xfer && in_last)) state_q <= DRAIN;
        DRAIN: if (pipe_empty && !fifo_valid) begin
          state_q <= DONE;
          done_q  <= 1'b1;
          cfgv_q  <= 1'b0;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FILTER_COND_CONTROL_STATS_EN
  logic [COUNT_WIDTH-1:0] passed_q, dropped_q;
  logic                   drop;
  assign drop = ret.valid && !keep;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      passed_q  <= '0;
      dropped_q <= '0;
    end else if (state_q == IDLE && start_in) begin
      passed_q  <= '0;
      dropped_q <= '0;
    end else begin
      if (keep && passed_q != '1)  passed_q  <= passed_q + COUNT_WIDTH'(1);
      if (drop && dropped_q != '1) dropped_q <= dropped_q + COUNT_WIDTH'(1);
    end
  end
  assign passed_count_out  = passed_q;
  assign dropped_count_out = dropped_q;
`else
  assign passed_count_out  = '0;
  assign dropped_count_out = '0;
`endif

endmodule

// File: tb/tb_engine_filter_cond_control.sv
module tb_engine_filter_cond_control;
  import engine_filter_cond_control_pkg::*;

  localparam int DEPTH = 4;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  logic start_in = 1'b0;
  FilterCondConfigurationParameters config_in = '0;
  logic in_valid = 1'b0;
  EnginePacketData in_data = '0;
  logic in_last = 1'b0;
  logic in_ready, out_valid, out_last;
  EnginePacketData out_data;
  logic out_ready = 1'b0;
  logic kernel_clear_out, kernel_config_valid_out, kernel_data_valid_out;
  FilterCondConfigurationParameters kernel_config_out;
  EnginePacketData kernel_data_out;
  logic kernel_result_flag_in;
  EnginePacketData kernel_result_data_in;
  logic busy_out, done_out, break_out;
  logic [31:0] passed_count_out, dropped_count_out;

  always #5 ap_clk = ~ap_clk;

  engine_filter_cond_control #(.FIFO_DEPTH(DEPTH), .COUNT_WIDTH(32)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start_in(start_in), .config_in(config_in),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .kernel_clear_out(kernel_clear_out), .kernel_config_valid_out(kernel_config_valid_out),
    .kernel_config_out(kernel_config_out), .kernel_data_valid_out(kernel_data_valid_out),
    .kernel_data_out(kernel_data_out), .kernel_result_flag_in(kernel_result_flag_in),
    .kernel_result_data_in(kernel_result_data_in), .busy_out(busy_out), .done_out(done_out),
    .break_out(break_out), .passed_count_out(passed_count_out),
    .dropped_count_out(dropped_count_out)
  );

  int checks = 0;
  int failures = 0;
  int done_seen = 0;
  int idx = 0;
  int exp_passed = 0;

  typedef struct packed { EnginePacketData d; logic last; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  EnginePacketData pk[$];

  // Filter rule of the kernel: mask bit 0 enables the compare.
  function automatic logic model_flag(FilterCondConfigurationParameters c, EnginePacketData p);
    if (!c.filter_mask[0]) return 1'b1;
    case (c.filter_op)
      FILTER_GT: return p.field_a > p.field_b;
      FILTER_LT: return p.field_a < p.field_b;
      FILTER_EQ: return p.field_a == p.field_b;
      default:   return 1'b1;
    endcase
  endfunction

  function automatic EnginePacketData mkp(int a, int b);
    EnginePacketData p;
    p.field_a = 16'(a);
    p.field_b = 16'(b);
    return p;
  endfunction

  function automatic logic [63:0] cnt(int v);
`ifdef FILTER_COND_CONTROL_STATS_EN
    return 64'(v);
`else
    return 64'(v * 0);
`endif
  endfunction

  // Kernel stand-in: two registered stages, flags held (stale) between packets.
  logic k1f, k2f;
  EnginePacketData k1d, k2d;
  always @(posedge ap_clk) begin
    if (!ap_rst_n || kernel_clear_out) begin
      k1f <= 1'b0; k2f <= 1'b0; k1d <= '0; k2d <= '0;
    end else begin
      if (kernel_data_valid_out) begin
        k1f <= model_flag(kernel_config_out, kernel_data_out);
        k1d <= kernel_data_out;
      end
      k2f <= k1f;
      k2d <= k1d;
    end
  end
  assign kernel_result_flag_in = k2f;
  assign kernel_result_data_in = k2d;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Output scoreboard, kernel passthrough check and FIFO bound.
  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL out_unexpected act=%0h exp=none", out_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(mon_e.d));
          chk("out_last", 64'(out_last), 64'(mon_e.last));
        end
      end
      if (in_valid && in_ready) begin
        chk("kdata_valid", 64'(kernel_data_valid_out), 64'd1);
        chk("kdata", 64'(kernel_data_out), 64'(in_data));
      end
      if (done_out) done_seen++;
      assert (int'(dut.fifo_cnt) <= DEPTH) else begin
        failures++;
        $display("FAIL fifo_overflow act=%0d limit=%0d", dut.fifo_cnt, DEPTH);
      end
    end
  end

  task automatic tick();
    @(posedge ap_clk); #1;
  endtask

  task automatic chk_zero(input string t);
    chk({t, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({t, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({t, "_out_data"}, 64'(out_data), 64'd0);
    chk({t, "_out_last"}, 64'(out_last), 64'd0);
    chk({t, "_kclear"}, 64'(kernel_clear_out), 64'd0);
    chk({t, "_kcfg_valid"}, 64'(kernel_config_valid_out), 64'd0);
    chk({t, "_kcfg"}, 64'(kernel_config_out), 64'd0);
    chk({t, "_kdata_valid"}, 64'(kernel_data_valid_out), 64'd0);
    chk({t, "_kdata"}, 64'(kernel_data_out), 64'd0);
    chk({t, "_busy"}, 64'(busy_out), 64'd0);
    chk({t, "_done"}, 64'(done_out), 64'd0);
    chk({t, "_break"}, 64'(break_out), 64'd0);
    chk({t, "_passed"}, 64'(passed_count_out), 64'd0);
    chk({t, "_dropped"}, 64'(dropped_count_out), 64'd0);
  endtask

  // Expected stream: flag=1 packets in order, stop at first fail under break,
  // out_last on the final kept packet.
  task automatic build_exp(input FilterCondConfigurationParameters c);
    exp_t e;
    exp_q.delete();
    foreach (pk[i]) begin
      if (model_flag(c, pk[i])) begin
        e.d = pk[i]; e.last = 1'b0; exp_q.push_back(e);
      end else if (c.break_pass) break;
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_back(); e.last = 1'b1; exp_q.push_back(e);
    end
    exp_passed = exp_q.size();
  endtask

  task automatic start_stream(input FilterCondConfigurationParameters c);
    idx = 0;
    config_in = c; start_in = 1'b1;
    tick();
    start_in = 1'b0; config_in = '0;
  endtask

  task automatic drive(input int maxc);
    logic acc;
    int n = 0;
    while (idx < pk.size() && n < maxc && !break_out) begin
      in_valid = 1'b1; in_data = pk[idx]; in_last = (idx == pk.size() - 1);
      @(negedge ap_clk); acc = in_ready;
      tick();
      if (acc) idx++;
      n++;
    end
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
  endtask

  task automatic wait_done(input string t, input int lit_pass, input int lit_drop);
    logic got = 1'b0;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge ap_clk); got = done_out;
    end
    chk({t, "_done_seen"}, 64'(got), 64'd1);
    chk({t, "_passed_model"}, 64'(passed_count_out), cnt(exp_passed));
    chk({t, "_dropped_model"}, 64'(dropped_count_out), cnt(idx - exp_passed));
    chk({t, "_passed_lit"}, 64'(passed_count_out), cnt(lit_pass));
    chk({t, "_dropped_lit"}, 64'(dropped_count_out), cnt(lit_drop));
    chk({t, "_exp_left"}, 64'(exp_q.size()), 64'd0);
    @(negedge ap_clk);
    chk({t, "_done_pulse"}, 64'(done_out), 64'd0);
    chk({t, "_busy_after"}, 64'(busy_out), 64'd0);
    chk({t, "_kcfgv_after"}, 64'(kernel_config_valid_out), 64'd0);
    tick();
  endtask

  task automatic run_basic(input string t);
    FilterCondConfigurationParameters c;
    c = '{filter_op: FILTER_GT, filter_mask: 4'b0001, break_pass: 1'b0};
    pk = '{mkp(5, 3), mkp(2, 7), mkp(9, 1)};
    build_exp(c);
    chk({t, "_model_n"}, 64'(exp_q.size()), 64'd2);
    chk({t, "_model_0"}, 64'(exp_q[0]), 64'({mkp(5, 3), 1'b0}));
    chk({t, "_model_1"}, 64'(exp_q[1]), 64'({mkp(9, 1), 1'b1}));
    out_ready = 1'b1;
    start_stream(c);
    @(negedge ap_clk);
    chk({t, "_kclear"}, 64'(kernel_clear_out), 64'd1);
    chk({t, "_kcfg"}, 64'(kernel_config_out), 64'(c));
    chk({t, "_kcfgv"}, 64'(kernel_config_valid_out), 64'd1);
    chk({t, "_busy"}, 64'(busy_out), 64'd1);
    tick();
    drive(50);
    wait_done(t, 2, 1);
  endtask

  initial begin
    FilterCondConfigurationParameters c, cb;

    repeat (3) tick();
    @(negedge ap_clk);
    chk_zero("reset");
    ap_rst_n = 1'b1;
    tick();

    // Pass-through, final packet kept.
    run_basic("t1");

    // Final packet dropped while buffered; start during RUN is ignored.
    c  = '{filter_op: FILTER_GT, filter_mask: 4'b0001, break_pass: 1'b0};
    cb = '{filter_op: FILTER_EQ, filter_mask: 4'b0011, break_pass: 1'b1};
    pk = '{mkp(5, 3), mkp(9, 1), mkp(2, 7)};
    build_exp(c);
    chk("t2_model_1", 64'(exp_q[1]), 64'({mkp(9, 1), 1'b1}));
    out_ready = 1'b0;
    start_stream(c);
    tick();
    config_in = cb; start_in = 1'b1;
    tick();
    start_in = 1'b0; config_in = '0;
    @(negedge ap_clk);
    chk("t2_cfg_kept", 64'(kernel_config_out), 64'(c));
    chk("t2_no_clear", 64'(kernel_clear_out), 64'd0);
    chk("t2_busy", 64'(busy_out), 64'd1);
    tick();
    drive(50);
    repeat (6) tick();
    out_ready = 1'b1;
    wait_done("t2", 2, 1);

    // Backpressure with a 4-entry FIFO.
    c = '{filter_op: FILTER_NOP, filter_mask: 4'b0001, break_pass: 1'b0};
    pk.delete();
    for (int i = 0; i < 10; i++) pk.push_back(mkp(i + 1, 100 - i));
    build_exp(c);
    chk("t3_model_n", 64'(exp_q.size()), 64'd10);
    out_ready = 1'b0;
    start_stream(c);
    drive(20);
    chk("t3_accepted", 64'(idx), 64'd4);
    @(negedge ap_clk);
    chk("t3_in_ready_low", 64'(in_ready), 64'd0);
    tick();
    out_ready = 1'b1;
    drive(200);
    chk("t3_all_issued", 64'(idx), 64'd10);
    wait_done("t3", 10, 0);

    // Break on first failing flag.
    c = '{filter_op: FILTER_EQ, filter_mask: 4'b0001, break_pass: 1'b1};
    pk = '{mkp(4, 4), mkp(4, 5), mkp(6, 6), mkp(7, 7)};
    build_exp(c);
    chk("t4_model", 64'(exp_q[0]), 64'({mkp(4, 4), 1'b1}));
    out_ready = 1'b0;
    start_stream(c);
    tick();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = pk[k]; in_last = (k == 3);
      @(negedge ap_clk);
      chk($sformatf("t4_rdy%0d", k), 64'(in_ready), 64'd1);
      if (k == 3) chk("t4_break_not_yet", 64'(break_out), 64'd0);
      tick();
    end
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    idx = 4;
    @(negedge ap_clk);
    chk("t4_rdy_low", 64'(in_ready), 64'd0);
    chk("t4_break", 64'(break_out), 64'd1);
    tick();
    repeat (4) tick();
    out_ready = 1'b1;
    wait_done("t4", 1, 3);
    chk("t4_break_held", 64'(break_out), 64'd1);

    // Reset with packets buffered.
    c = '{filter_op: FILTER_NOP, filter_mask: 4'b0001, break_pass: 1'b0};
    pk = '{mkp(1, 2), mkp(3, 4), mkp(5, 6)};
    build_exp(c);
    out_ready = 1'b0;
    start_stream(c);
    @(negedge ap_clk);
    chk("t5_break_cleared", 64'(break_out), 64'd0);
    tick();
    drive(20);
    repeat (4) tick();
    @(negedge ap_clk);
    chk("t5_buffered", 64'(out_valid), 64'd1);
    tick();
    ap_rst_n = 1'b0;
    exp_q.delete();
    tick();
    begin
      int d0;
      d0 = done_seen;
      @(negedge ap_clk);
      chk_zero("t5_rst");
      tick();
      ap_rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (6) tick();
      chk("t5_no_done", 64'(done_seen), 64'(d0));
    end

    // Clean stream after reset.
    run_basic("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
